// File: rtl/wb_pkg.sv
// Shared definitions for the write-back buffer slice.
//   DATA_W_DEF / ADDR_W_DEF : default result and register-index widths
//   wb_entry_t              : one pending register-file write {addr, data}
//   cnt_w()                 : width needed to hold an occupancy of 0..depth
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_buffer_if.sv
// Bus bundle between the execute stage / decode bypass and the write-back buffer.
//   in_valid/in_ready/in_addr/in_data : result push handshake
//   wb_stall                          : register-file write port borrowed, hold drain
//   we2/wa3/wd3                       : register-file write port
//   ra1/ra2                           : decode read addresses for bypass lookup
//   byp1_hit/byp1_data, byp2_*        : bypass result per read port
// Modports: master = producer/consumer side, slave = the buffer.
interface wb_buffer_if
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              wb_stall;
  logic              we2;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic              byp1_hit;
  logic              byp2_hit;
  logic [DATA_W-1:0] byp1_data;
  logic [DATA_W-1:0] byp2_data;

  modport master (
    output in_valid, in_addr, in_data, wb_stall, ra1, ra2,
    input  in_ready, we2, wa3, wd3, byp1_hit, byp2_hit, byp1_data, byp2_data
  );

  modport slave (
    input  in_valid, in_addr, in_data, wb_stall, ra1, ra2,
    output in_ready, we2, wa3, wd3, byp1_hit, byp2_hit, byp1_data, byp2_data
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular storage for pending register-file writes: entry arrays, read/write
// pointers and occupancy count. Storage is not reset; only control state is.
//   clk, rst           : clock, synchronous active-high reset
//   i_push, i_addr/data: store one entry at the write pointer
//   i_pop              : retire the entry at the read pointer
//   o_count            : occupancy 0..DEPTH
//   o_rd_ptr           : index of the oldest entry
//   o_head_addr/data   : oldest entry (combinational)
//   o_mem_addr/data    : raw storage view for bypass lookup
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_push,
  input  logic [ADDR_W-1:0]                  i_addr,
  input  logic [DATA_W-1:0]                  i_data,
  input  logic                               i_pop,
  output logic [$clog2(DEPTH):0]             o_count,
  output logic [$clog2(DEPTH)-1:0]           o_rd_ptr,
  output logic [ADDR_W-1:0]                  o_head_addr,
  output logic [DATA_W-1:0]                  o_head_data,
  output logic [DEPTH-1:0][ADDR_W-1:0]       o_mem_addr,
  output logic [DEPTH-1:0][DATA_W-1:0]       o_mem_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Local guards keep the count inside 0..DEPTH even if a caller misbehaves.
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !w_empty;

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage: written only, never reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem_addr[r_wr_ptr] <= i_addr;
      r_mem_data[r_wr_ptr] <= i_data;
    end
  end

  assign o_count     = r_count;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_head_addr = r_mem_addr[r_rd_ptr];
  assign o_head_data = r_mem_data[r_rd_ptr];

  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    assign o_mem_addr[g] = r_mem_addr[g];
    assign o_mem_data[g] = r_mem_data[g];
  end

endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer: queues execute results and drains them into the register
// file write port whenever that port is free, with optional decode bypass.
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_buffer_if.slave (push handshake, RF write port, bypass)
// Parameters: DATA_W result width, ADDR_W register index width, DEPTH entries
// (power of two, >= 2).
// Build option: define WB_BUFFER_BYPASS_EN to build the bypass compare logic;
// otherwise byp*_hit / byp*_data are tied to 0.
module wb_buffer
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_buffer_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [CNT_W-1:0]              w_count;
  logic [PTR_W-1:0]              w_rd_ptr;
  logic [ADDR_W-1:0]             w_head_addr;
  logic [DATA_W-1:0]             w_head_data;
  logic [DEPTH-1:0][ADDR_W-1:0]  w_mem_addr;
  logic [DEPTH-1:0][DATA_W-1:0]  w_mem_data;
  logic                          w_ready;
  logic                          w_push;
  logic                          w_pop;

  // Readiness looks only at the current count, never at a same-cycle drain.
  assign w_ready = (w_count < CNT_W'(DEPTH));
  // Writes to x0 are handshaken normally but never stored.
  assign w_push  = bus.in_valid && w_ready && (bus.in_addr != '0);
  assign w_pop   = (w_count != '0) && !bus.wb_stall;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_addr      (bus.in_addr),
    .i_data      (bus.in_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_rd_ptr    (w_rd_ptr),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_mem_addr  (w_mem_addr),
    .o_mem_data  (w_mem_data)
  );

  assign bus.in_ready = w_ready;
  assign bus.we2      = w_pop;
  assign bus.wa3      = w_head_addr;
  assign bus.wd3      = w_head_data;

`ifdef WB_BUFFER_BYPASS_EN
  logic              w_byp1_hit;
  logic              w_byp2_hit;
  logic [DATA_W-1:0] w_byp1_data;
  logic [DATA_W-1:0] w_byp2_data;
  logic [PTR_W-1:0]  w_idx;

  // Walk entries oldest to youngest so a later match overrides an earlier
  // one, leaving the youngest matching value. The head entry counts even in
  // the cycle it is being written; the incoming in_data is not visible.
  always_comb begin
    w_byp1_hit  = 1'b0;
    w_byp2_hit  = 1'b0;
    w_byp1_data = '0;
    w_byp2_data = '0;
    w_idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = w_rd_ptr + PTR_W'(k);
      if (CNT_W'(k) < w_count) begin
        if ((bus.ra1 != '0) && (w_mem_addr[w_idx] == bus.ra1)) begin
          w_byp1_hit  = 1'b1;
          w_byp1_data = w_mem_data[w_idx];
        end
        if ((bus.ra2 != '0) && (w_mem_addr[w_idx] == bus.ra2)) begin
          w_byp2_hit  = 1'b1;
          w_byp2_data = w_mem_data[w_idx];
        end
      end
    end
  end

  assign bus.byp1_hit  = w_byp1_hit;
  assign bus.byp2_hit  = w_byp2_hit;
  assign bus.byp1_data = w_byp1_data;
  assign bus.byp2_data = w_byp2_data;
`else
  logic w_unused;

  assign bus.byp1_hit  = 1'b0;
  assign bus.byp2_hit  = 1'b0;
  assign bus.byp1_data = '0;
  assign bus.byp2_data = '0;
  // Storage view and read addresses are only consumed by the bypass.
  assign w_unused = ^{bus.ra1, bus.ra2, w_rd_ptr, w_mem_addr, w_mem_data};
`endif

endmodule

// File: tb/tb_wb_buffer.sv
// Scoreboard bench for wb_buffer: accepted non-x0 pushes queue their expected
// register-file write; a monitor pops and compares on every we2 cycle.
module tb_wb_buffer;
  import wb_pkg::*;

  localparam bit BYP =
`ifdef WB_BUFFER_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  wb_entry_t exp_q[$];

  wb_buffer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT issues must be the next expected one.
  initial begin
    wb_entry_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.we2) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got wa3=%0h wd3=%0h expected none", bus.wa3, bus.wd3);
        end else begin
          e = exp_q.pop_front();
          chk("wa3", 32'(bus.wa3), 32'(e.addr));
          chk("wd3", bus.wd3, e.data);
        end
      end
    end
  end

  // Push one result; held until accepted or the bound expires.
  task automatic push(input logic [4:0] a, input logic [31:0] d);
    bit ok;
    wb_entry_t e;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        if (a != 5'd0) begin
          e.addr = a;
          e.data = d;
          exp_q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.we2) return;
    end
    total++;
    bad++;
    $display("FAIL drain_timeout: got we2=1 expected 0 within 20 cycles");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.wb_stall = 1'b0;
    bus.ra1      = '0;
    bus.ra2      = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_we2", 32'(bus.we2), 32'd0);
    chk("rst_byp1_hit", 32'(bus.byp1_hit), 32'd0);
    chk("rst_byp2_hit", 32'(bus.byp2_hit), 32'd0);

    // Single write with one-cycle latency
    push(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_we2", 32'(bus.we2), 32'd1);
    @(negedge clk);
    chk("single_we2_off", 32'(bus.we2), 32'd0);

    // Fill while stalled, then drain on consecutive cycles
    bus.wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) push(5'(i), 32'hA000_0000 + 32'(i));
    @(negedge clk);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 bus.wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fill_we2", 32'(bus.we2), 32'd1);
    end
    @(negedge clk);
    chk("fill_done_we2", 32'(bus.we2), 32'd0);
    chk("fill_done_ready", 32'(bus.in_ready), 32'd1);

    // x0 writes are dropped: four of them must not fill the buffer
    push(5'd0, 32'h1234);
    @(negedge clk);
    chk("x0_we2", 32'(bus.we2), 32'd0);
    chk("x0_ready", 32'(bus.in_ready), 32'd1);
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) push(5'd0, 32'h1234);
    @(negedge clk);
    chk("x0_count_ready", 32'(bus.in_ready), 32'd1);

    // Full with simultaneous drain: push refused this cycle, accepted next
    for (int i = 0; i < 4; i++) push(5'(16 + i), 32'hB000_0000 + 32'(i));
    @(posedge clk);
    #1;
    bus.wb_stall = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_addr  = 5'd9;
    bus.in_data  = 32'h99;
    @(negedge clk);
    chk("full_pp_ready", 32'(bus.in_ready), 32'd0);
    chk("full_pp_we2", 32'(bus.we2), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("full_pp_ready_next", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) exp_q.push_back('{addr: 5'd9, data: 32'h99});
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain();

    // Bypass: youngest match wins, ra == 0 never hits
    bus.wb_stall = 1'b1;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    push(5'd3, 32'h33);
    bus.ra1 = 5'd7;
    bus.ra2 = 5'd0;
    @(negedge clk);
    chk("byp1_hit", 32'(bus.byp1_hit), BYP ? 32'd1 : 32'd0);
    chk("byp1_data", bus.byp1_data, BYP ? 32'h22 : 32'h0);
    chk("byp2_hit_x0", 32'(bus.byp2_hit), 32'd0);
    bus.ra2 = 5'd3;
    @(negedge clk);
    chk("byp2_hit", 32'(bus.byp2_hit), BYP ? 32'd1 : 32'd0);
    chk("byp2_data", bus.byp2_data, BYP ? 32'h33 : 32'h0);
    bus.ra2 = 5'd12;
    @(negedge clk);
    chk("byp2_miss", 32'(bus.byp2_hit), 32'd0);
    @(posedge clk);
    #1 bus.wb_stall = 1'b0;
    drain();
    bus.ra1 = '0;
    bus.ra2 = '0;

    // Reset mid-drain: pending entries are lost
    bus.wb_stall = 1'b1;
    push(5'd10, 32'hC0);
    push(5'd11, 32'hC1);
    push(5'd12, 32'hC2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wb_stall = 1'b0;
    bus.ra1 = 5'd10;
    exp_q.delete();
    @(negedge clk);
    chk("rstmid_we2", 32'(bus.we2), 32'd0);
    chk("rstmid_ready", 32'(bus.in_ready), 32'd1);
    chk("rstmid_byp1", 32'(bus.byp1_hit), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("rstmid_no_write", 32'(bus.we2), 32'd0);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
